// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, instruction
// field positions and the default reset program counter.
package instr_fetch_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  // Low bit position of each 4-bit nibble in the 16-bit instruction word
  localparam int OP_HI  = 12;  // inst[15:12], upper opcode nibble
  localparam int RDEST  = 8;   // inst[11:8], destination register
  localparam int OP_EXT = 4;   // inst[7:4], opcode extension nibble
  localparam int RSRC   = 0;   // inst[3:0], source register

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

endpackage

// File: rtl/instr_decode.sv
// Purely combinational field extraction from a 16-bit instruction word.
module instr_decode
  import instr_fetch_pkg::*;
(
  input  logic [15:0] inst,
  output logic [7:0]  opcode,
  output logic [3:0]  reg_s1,
  output logic [3:0]  reg_s2,
  output logic [7:0]  imm_val
);

  // Slice the word into its decoded fields
  always_comb begin
    opcode  = {inst[OP_HI +: 4], inst[OP_EXT +: 4]};
    reg_s1  = inst[RDEST +: 4];
    reg_s2  = inst[RSRC +: 4];
    imm_val = inst[7:0];
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks the program counter through a synchronous
// ROM, holds each fetched word in an instruction register and presents the
// decoded fields to the downstream FSM.
//
// Handshake: ins_valid is high only in HOLD; a transfer happens on a rising
// edge where ins_valid and ins_ready are both 1. Once ins_valid rises, the
// fields and pc stay stable until that transfer, a pc_load or a reset.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              Clocks,
  input  logic              reset,
  input  logic              en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [7:0]        opcode,
  output logic [3:0]        reg_s1,
  output logic [3:0]        reg_s2,
  output logic [7:0]        imm_val,
  output logic [ADDR_W-1:0] pc,
  output fetch_state_e      state_dbg
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              transfer;

  // Outputs come straight from flops so mem_rdata never reaches them directly
  always_comb begin
    ins_valid = (state_q == HOLD);
    transfer  = ins_valid && ins_ready;
    mem_addr  = pc_q;
    pc        = pc_q;
    state_dbg = state_q;
  end

  // Next state, pc and instruction register; redirect overrides everything
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      IDLE:  if (en) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        ir_d    = mem_rdata;
        state_d = HOLD;
      end
      HOLD: begin
        if (transfer) begin
          pc_d    = pc_q + ADDR_W'(1);  // wraps naturally at the top of memory
          state_d = en ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A redirect drops any word in flight; the register keeps its old value
    // so the fields stay steady while ins_valid is low.
    if (pc_load) begin
      pc_d    = pc_target;
      ir_d    = ir_q;
      state_d = en ? ISSUE : IDLE;
    end
  end

  // State registers with synchronous reset taking precedence over all inputs
  always_ff @(posedge Clocks) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  instr_decode u_decode (
    .inst    (ir_q),
    .opcode  (opcode),
    .reg_s1  (reg_s1),
    .reg_s2  (reg_s2),
    .imm_val (imm_val)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a small synchronous ROM model.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk;
  logic        reset;
  logic        en;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        pc_load;
  logic [15:0] pc_target;
  logic        ins_valid;
  logic        ins_ready;
  logic [7:0]  opcode;
  logic [3:0]  reg_s1;
  logic [3:0]  reg_s2;
  logic [7:0]  imm_val;
  logic [15:0] pc;
  fetch_state_e state_dbg;

  int n_vec;
  int n_err;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  instr_fetch dut (
    .Clocks    (clk),
    .reset     (reset),
    .en        (en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .pc_load   (pc_load),
    .pc_target (pc_target),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .opcode    (opcode),
    .reg_s1    (reg_s1),
    .reg_s2    (reg_s2),
    .imm_val   (imm_val),
    .pc        (pc),
    .state_dbg (state_dbg)
  );

  // ROM contents: a few hand-placed words, everything else address ^ A5A5
  function automatic logic [15:0] rom_word(input logic [15:0] a);
    case (a)
      16'h0000: rom_word = 16'h5A3C;
      16'h0001: rom_word = 16'h1234;
      16'h0040: rom_word = 16'hC7E1;
      16'hFFFF: rom_word = 16'h9876;
      default:  rom_word = a ^ 16'hA5A5;
    endcase
  endfunction

  // Synchronous ROM: data appears one cycle after the address
  always @(posedge clk) mem_rdata <= rom_word(mem_addr);

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Scoreboard check
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_fields(input string tag, input logic [7:0] op, input logic [3:0] s1,
                              input logic [3:0] s2, input logic [7:0] imm);
    check_eq({tag, ".opcode"}, 32'(opcode), 32'(op));
    check_eq({tag, ".reg_s1"}, 32'(reg_s1), 32'(s1));
    check_eq({tag, ".reg_s2"}, 32'(reg_s2), 32'(s2));
    check_eq({tag, ".imm_val"}, 32'(imm_val), 32'(imm));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    en = 1'b0;
    ins_ready = 1'b0;
    pc_load = 1'b0;
    pc_target = 16'h0000;

    // Reset state
    ticks(2);
    check_eq("rst.valid", 32'(ins_valid), 32'd0);
    check_eq("rst.pc", 32'(pc), 32'h0);
    check_eq("rst.addr", 32'(mem_addr), 32'h0);
    check_eq("rst.state", 32'(state_dbg), 32'(IDLE));
    check_fields("rst", 8'h00, 4'h0, 4'h0, 8'h00);

    // Reset wins over en and pc_load on the same edge
    en = 1'b1; pc_load = 1'b1; pc_target = 16'h0077;
    tick();
    check_eq("rstpri.pc", 32'(pc), 32'h0);
    check_eq("rstpri.state", 32'(state_dbg), 32'(IDLE));

    // First fetch of ROM[0] with ready held high
    reset = 1'b0; pc_load = 1'b0; en = 1'b1; ins_ready = 1'b1;
    tick();
    check_eq("f0.e1.state", 32'(state_dbg), 32'(ISSUE));
    check_eq("f0.e1.valid", 32'(ins_valid), 32'd0);
    tick();
    check_eq("f0.e2.valid", 32'(ins_valid), 32'd0);
    tick();
    check_eq("f0.e3.valid", 32'(ins_valid), 32'd1);
    check_eq("f0.pc", 32'(pc), 32'h0);
    check_fields("f0", 8'h53, 4'hA, 4'hC, 8'h3C);
    tick();
    check_eq("f0.xfer.pc", 32'(pc), 32'h1);
    check_eq("f0.xfer.valid", 32'(ins_valid), 32'd0);

    // Backpressure: ROM[1] held for 5 cycles
    ins_ready = 1'b0;
    ticks(2);
    check_eq("f1.valid", 32'(ins_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp.valid", 32'(ins_valid), 32'd1);
      check_eq("bp.pc", 32'(pc), 32'h1);
      check_eq("bp.opcode", 32'(opcode), 32'h13);
    end
    check_fields("f1", 8'h13, 4'h2, 4'h4, 8'h34);
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    check_eq("bp.xfer.pc", 32'(pc), 32'h2);
    ticks(2);
    check_eq("f2.valid", 32'(ins_valid), 32'd1);
    check_eq("f2.pc", 32'(pc), 32'h2);
    check_eq("f2.opcode", 32'(opcode), 32'hAA);

    // en dropped in HOLD: word is kept until accepted, then idle
    en = 1'b0;
    tick();
    check_eq("endrop.valid", 32'(ins_valid), 32'd1);
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    check_eq("endrop.pc", 32'(pc), 32'h3);
    check_eq("endrop.state", 32'(state_dbg), 32'(IDLE));
    tick();
    check_eq("idle.valid", 32'(ins_valid), 32'd0);
    check_eq("idle.pc", 32'(pc), 32'h3);

    // Redirect from IDLE to FFFF, then wrap on transfer
    pc_load = 1'b1; pc_target = 16'hFFFF; en = 1'b1;
    tick();
    pc_load = 1'b0;
    check_eq("ld.pc", 32'(pc), 32'hFFFF);
    check_eq("ld.state", 32'(state_dbg), 32'(ISSUE));
    ticks(2);
    check_eq("ffff.valid", 32'(ins_valid), 32'd1);
    check_eq("ffff.opcode", 32'(opcode), 32'h97);
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    check_eq("wrap.pc", 32'(pc), 32'h0);
    check_eq("wrap.addr", 32'(mem_addr), 32'h0);
    check_eq("wrap.state", 32'(state_dbg), 32'(ISSUE));

    // Redirect during WAIT discards the word in flight
    tick();
    check_eq("w.state", 32'(state_dbg), 32'(WAIT));
    pc_load = 1'b1; pc_target = 16'h0040;
    tick();
    pc_load = 1'b0;
    check_eq("ldw.pc", 32'(pc), 32'h40);
    check_eq("ldw.valid", 32'(ins_valid), 32'd0);
    check_eq("ldw.hold_op", 32'(opcode), 32'h97);
    ticks(2);
    check_eq("f40.valid", 32'(ins_valid), 32'd1);
    check_fields("f40", 8'hCE, 4'h7, 4'h1, 8'hE1);

    // Transfer and redirect on the same edge: target wins over pc+1
    ins_ready = 1'b1; pc_load = 1'b1; pc_target = 16'h0010;
    tick();
    ins_ready = 1'b0; pc_load = 1'b0;
    check_eq("xld.pc", 32'(pc), 32'h10);
    check_eq("xld.valid", 32'(ins_valid), 32'd0);
    ticks(2);
    check_eq("f10.opcode", 32'(opcode), 32'hAB);

    // Reset in WAIT abandons the fetch
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    tick();
    check_eq("rw.state", 32'(state_dbg), 32'(WAIT));
    reset = 1'b1;
    tick();
    reset = 1'b0; en = 1'b0;
    check_eq("rw.pc", 32'(pc), 32'h0);
    check_eq("rw.addr", 32'(mem_addr), 32'h0);
    check_eq("rw.valid", 32'(ins_valid), 32'd0);
    check_fields("rw", 8'h00, 4'h0, 4'h0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rw.after.valid", 32'(ins_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: program counter value after reset.
REQ-002 Parameter ADDR_W, default 16: width of pc, mem_addr and pc_target.
REQ-003 Clocks  input  1  single rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clocks.
REQ-005 en  input  1  run enable; 0 = stop fetching after the current instruction is accepted.
REQ-006 mem_addr  output  ADDR_W  instruction memory address; always equals pc.
REQ-007 mem_rdata  input  16  instruction word; valid exactly one cycle after mem_addr is presented (synchronous ROM).
REQ-008 pc_load  input  1  one-cycle redirect strobe (branch/jump) from the downstream FSM.
REQ-009 pc_target  input  ADDR_W  redirect address, sampled when pc_load=1.
REQ-010 ins_valid  output  1  decoded instruction fields are valid.
REQ-011 ins_ready  input  1  downstream FSM accepts the instruction; a transfer occurs when ins_valid and ins_ready are both 1 on a rising edge.
REQ-012 opcode  output  8  {inst[15:12], inst[7:4]}.
REQ-013 reg_s1  output  4  inst[11:8] (Rdest).
REQ-014 reg_s2  output  4  inst[3:0] (Rsrc).
REQ-015 imm_val  output  8  inst[7:0].
REQ-016 pc  output  ADDR_W  address of the instruction currently held or being fetched.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE, WAIT and HOLD.
REQ-018 IDLE: ins_valid=0; when en=1, go to ISSUE on the next edge.
REQ-019 ISSUE: mem_addr=pc; always go to WAIT.
REQ-020 WAIT: capture mem_rdata into the instruction register; go to HOLD.
REQ-021 HOLD: ins_valid=1 and fields stable until a transfer occurs.
REQ-022 On a transfer in HOLD: pc<=pc+1; go to ISSUE if en=1, else go to IDLE.
REQ-023 Latency SHALL be exactly 2 cycles from entering ISSUE to ins_valid=1, which gives a peak throughput of 1 instruction per 3 cycles.
REQ-024 pc increment SHALL wrap modulo 2^ADDR_W (16'hFFFF+1 -> 16'h0000).
REQ-025 pc_load SHALL take priority over every other event in every state: pc<=pc_target, instruction register discarded, ins_valid=0 on the next cycle, and the next state is ISSUE if en=1, else IDLE.
REQ-026 If pc_load and a transfer occur on the same edge, the transfer completes and pc takes pc_target; pc+1 is NOT applied.
REQ-027 Deasserting en while in ISSUE, WAIT or HOLD SHALL NOT drop a fetch in progress; the instruction is presented and held until accepted.
REQ-028 Decoded fields SHALL be driven from registers with no combinational path from mem_rdata to the outputs.
REQ-029 Fields SHALL hold their last value while ins_valid=0.

Reset
REQ-030 On reset=1 at a rising edge: state=IDLE, pc=RESET_PC, mem_addr=RESET_PC, ins_valid=0, instruction register=16'h0000, so opcode, reg_s1, reg_s2 and imm_val are all 0.
REQ-031 Reset SHALL override pc_load, en and any transfer on the same edge.
REQ-032 Reset asserted mid-fetch SHALL abandon the fetch; no partial instruction is presented afterwards.

Structure
REQ-033 A shared package SHALL hold the state enum, the field bit positions (OP_HI, RDEST, OP_EXT, RSRC) and the RESET_PC default.
REQ-034 A single combinational sub-module, instr_decode, SHALL map the 16-bit word to opcode, reg_s1, reg_s2 and imm_val; no other sub-modules are used.

Verification
REQ-035 Reset, then en=1 with ROM[0]=16'h5A3C and ins_ready held 1 -> ins_valid rises on the 3rd edge after en; opcode=8'h53, reg_s1=4'hA, reg_s2=4'hC, imm_val=8'h3C; pc becomes 1 after the transfer.
REQ-036 Hold ins_ready=0 for 5 cycles while in HOLD -> ins_valid stays 1, fields and pc are unchanged; one cycle of ins_ready=1 -> exactly one transfer, then pc=pc+1.
REQ-037 pc=16'hFFFF, transfer -> pc=16'h0000 and mem_addr=16'h0000 on the next ISSUE.
REQ-038 pc_load=1 with pc_target=16'h0040 during WAIT -> the fetched word is discarded, ins_valid=0, and the next valid instruction is ROM[0x40].
REQ-039 Simultaneous transfer and pc_load (target 16'h0010) -> pc=16'h0010, not pc+1; reset asserted in WAIT -> all outputs return to their reset values on the next edge.
